// File: rtl/max_pool_layer_if.sv
// Bundle between conv_layer's output map and the max-pool stage: input map,
// start level, pooled map, and status flags.
interface max_pool_layer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int INROW      = 24,
   parameter int INCOL      = 24,
   parameter int POOL       = 2
);
   localparam int OROW = INROW / POOL;
   localparam int OCOL = INCOL / POOL;

   // Handshake: a rising edge on start_in (seen by the block's clock) starts a
   // pass unless one is running; feature_in must stay constant until
   // layer_done_out rises, and layer_done_out stays high until the next start.
   logic [DATA_WIDTH-1:0] feature_in [0:INROW-1][0:INCOL-1];
   logic                  start_in;
   logic [DATA_WIDTH-1:0] pool_out [0:OROW-1][0:OCOL-1];
   logic                  busy;
   logic                  layer_done_out;
   logic [1:0]            state_dbg;

   modport master (
      output feature_in, start_in,
      input  pool_out, busy, layer_done_out, state_dbg
   );
   modport slave (
      input  feature_in, start_in,
      output pool_out, busy, layer_done_out, state_dbg
   );
endinterface

// File: rtl/max_pool_layer.sv
// Sequential POOLxPOOL / stride POOL max pooling: one input sample per clock,
// one registered output pixel written per completed window.
module max_pool_layer #(
   parameter int DATA_WIDTH = 8,
   parameter int INROW      = 24,
   parameter int INCOL      = 24,
   parameter int POOL       = 2,
   parameter int SIGNED     = 0
) (
   input logic              clk,
   input logic              rst,
   max_pool_layer_if.slave  pool_if
);
   localparam int OROW = INROW / POOL;
   localparam int OCOL = INCOL / POOL;
   localparam int KW   = $clog2(POOL);
   localparam int RW   = (OROW > 1) ? $clog2(OROW) : 1;
   localparam int CW   = (OCOL > 1) ? $clog2(OCOL) : 1;
   localparam int IRW  = $clog2(INROW);
   localparam int ICW  = $clog2(INCOL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_n;
   logic                  start_q;
   logic [RW-1:0]         orow;
   logic [CW-1:0]         ocol;
   logic [KW-1:0]         kr, kc;
   logic [DATA_WIDTH-1:0] runmax;

   logic                  start_edge, win_first, win_last, pix_last, s_gt;
   logic [IRW-1:0]        in_r;
   logic [ICW-1:0]        in_c;
   logic [DATA_WIDTH-1:0] sample, win_max;

   always_comb begin
      start_edge = pool_if.start_in & ~start_q;
      win_first  = (kr == '0) && (kc == '0);
      win_last   = (kr == KW'(POOL-1)) && (kc == KW'(POOL-1));
      pix_last   = win_last && (orow == RW'(OROW-1)) && (ocol == CW'(OCOL-1));
      in_r       = IRW'(orow * POOL + kr);
      in_c       = ICW'(ocol * POOL + kc);
      sample     = pool_if.feature_in[in_r][in_c];
      if (SIGNED != 0) s_gt = $signed(sample) > $signed(runmax);
      else             s_gt = sample > runmax;
      // First sample of a window replaces the stale max of the previous window.
      win_max    = (win_first || s_gt) ? sample : runmax;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n                = state;
      pool_if.busy           = 1'b0;
      pool_if.layer_done_out = 1'b0;
      pool_if.state_dbg      = state;
      case (state)
         IDLE: if (start_edge) state_n = RUN;
         RUN: begin
            pool_if.busy = 1'b1;
            if (pix_last) state_n = DONE;
         end
         DONE: begin
            pool_if.layer_done_out = 1'b1;
            if (start_edge) state_n = RUN;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_q <= 1'b0;
         orow    <= '0;
         ocol    <= '0;
         kr      <= '0;
         kc      <= '0;
         runmax  <= '0;
         for (int i = 0; i < OROW; i++)
            for (int j = 0; j < OCOL; j++)
               pool_if.pool_out[i][j] <= '0;
      end else begin
         start_q <= pool_if.start_in;
         if (state != RUN && start_edge) begin
            orow <= '0;
            ocol <= '0;
            kr   <= '0;
            kc   <= '0;
            for (int i = 0; i < OROW; i++)
               for (int j = 0; j < OCOL; j++)
                  pool_if.pool_out[i][j] <= '0;
         end else if (state == RUN) begin
            runmax <= win_max;
            if (win_last) pool_if.pool_out[orow][ocol] <= win_max;
            // Column-in-window fastest, then row-in-window, then output column/row.
            if (kc == KW'(POOL-1)) begin
               kc <= '0;
               if (kr == KW'(POOL-1)) begin
                  kr <= '0;
                  if (ocol == CW'(OCOL-1)) begin
                     ocol <= '0;
                     if (orow == RW'(OROW-1)) orow <= '0;
                     else                     orow <= orow + 1'b1;
                  end else begin
                     ocol <= ocol + 1'b1;
                  end
               end else begin
                  kr <= kr + 1'b1;
               end
            end else begin
               kc <= kc + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_max_pool_layer.sv
// Bench for max_pool_layer: a 24x24 unsigned instance plus 5x5 unsigned and signed
// instances sharing one input map, all checked against a window-max model.
module tb_max_pool_layer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   max_pool_layer_if #(.DATA_WIDTH(8), .INROW(24), .INCOL(24), .POOL(2)) m_if ();
   max_pool_layer_if #(.DATA_WIDTH(8), .INROW(5),  .INCOL(5),  .POOL(2)) o_if ();
   max_pool_layer_if #(.DATA_WIDTH(8), .INROW(5),  .INCOL(5),  .POOL(2)) s_if ();

   max_pool_layer #(.DATA_WIDTH(8), .INROW(24), .INCOL(24), .POOL(2), .SIGNED(0))
      u_main (.clk(clk), .rst(rst), .pool_if(m_if.slave));
   max_pool_layer #(.DATA_WIDTH(8), .INROW(5), .INCOL(5), .POOL(2), .SIGNED(0))
      u_odd (.clk(clk), .rst(rst), .pool_if(o_if.slave));
   max_pool_layer #(.DATA_WIDTH(8), .INROW(5), .INCOL(5), .POOL(2), .SIGNED(1))
      u_sgn (.clk(clk), .rst(rst), .pool_if(s_if.slave));

   logic [7:0] fm [0:23][0:23];
   logic [7:0] fo [0:4][0:4];
   logic       start_m = 1'b0;
   logic       start_s = 1'b0;

   assign m_if.feature_in = fm;
   assign o_if.feature_in = fo;
   assign s_if.feature_in = fo;
   assign m_if.start_in   = start_m;
   assign o_if.start_in   = start_s;
   assign s_if.start_in   = start_s;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
      end
   endtask

   // ---------------- accessors ----------------
   function automatic int rows_of(input int k);
      return (k == 0) ? 24 : 5;
   endfunction

   function automatic int n_of(input int k);
      return (rows_of(k) / 2) * (rows_of(k) / 2) * 4;
   endfunction

   function automatic logic [7:0] feat(input int k, input int r, input int c);
      if (k == 0) return fm[r][c];
      return fo[r][c];
   endfunction

   function automatic logic [7:0] got(input int k, input int i, input int j);
      if (k == 0) return m_if.pool_out[i][j];
      if (k == 1) return o_if.pool_out[i][j];
      return s_if.pool_out[i][j];
   endfunction

   function automatic logic dut_busy(input int k);
      if (k == 0) return m_if.busy;
      if (k == 1) return o_if.busy;
      return s_if.busy;
   endfunction

   function automatic logic dut_done(input int k);
      if (k == 0) return m_if.layer_done_out;
      if (k == 1) return o_if.layer_done_out;
      return s_if.layer_done_out;
   endfunction

   function automatic logic st(input int k);
      return (k == 0) ? start_m : start_s;
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] exp_pool [0:2][0:11][0:11];

   function automatic bit beats(input logic [7:0] a, input logic [7:0] b, input bit sgn);
      if (sgn) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   function automatic void compute(input int k);
      logic [7:0] best, v;
      for (int i = 0; i < rows_of(k) / 2; i++)
         for (int j = 0; j < rows_of(k) / 2; j++) begin
            best = feat(k, 2*i, 2*j);
            for (int dr = 0; dr < 2; dr++)
               for (int dc = 0; dc < 2; dc++) begin
                  v = feat(k, 2*i + dr, 2*j + dc);
                  if (beats(v, best, k == 2)) best = v;
               end
            exp_pool[k][i][j] = best;
         end
   endfunction

   int run_left [3];
   bit m_busy [3], m_done [3], m_prev [3], fresh [3], just_started [3];
   bit m_edge;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            run_left[k] = 0; m_busy[k] = 0; m_done[k] = 0;
            m_prev[k] = 0; fresh[k] = 0; just_started[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_edge    = st(k) & ~m_prev[k];
            m_prev[k] = st(k);
            if (m_busy[k]) begin
               run_left[k]--;
               if (run_left[k] == 0) begin
                  m_busy[k] = 0; m_done[k] = 1; fresh[k] = 1;
               end
            end else if (m_edge) begin
               m_busy[k] = 1; m_done[k] = 0; just_started[k] = 1;
               run_left[k] = n_of(k);
               compute(k);
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         check("busy", k, 32'(dut_busy(k)), 32'(m_busy[k]));
         check("done", k, 32'(dut_done(k)), 32'(m_done[k]));
         if (just_started[k]) begin
            check("clear_on_start", k, 32'(got(k, 0, 0)), 32'h0);
            just_started[k] = 0;
         end
         if (fresh[k]) begin
            for (int i = 0; i < rows_of(k) / 2; i++)
               for (int j = 0; j < rows_of(k) / 2; j++)
                  exp_q.push_back(exp_pool[k][i][j]);
            for (int i = 0; i < rows_of(k) / 2; i++)
               for (int j = 0; j < rows_of(k) / 2; j++)
                  check($sformatf("pool[%0d][%0d]", i, j), k, 32'(got(k, i, j)),
                        32'(exp_q.pop_front()));
            fresh[k] = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(input int k, input int pulse_at, output int cyc);
      cyc = 0;
      while (cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            check("busy_after_start", k, 32'(dut_busy(k)), 32'h1);
            check("done_falls", k, 32'(dut_done(k)), 32'h0);
         end
         if (pulse_at > 0 && cyc == pulse_at)     start_m = 1'b0;
         if (pulse_at > 0 && cyc == pulse_at + 3) start_m = 1'b1;
         if (dut_done(k)) break;
      end
      if (!dut_done(k)) check("done_timeout", k, 32'h0, 32'h1);
   endtask

   task automatic run(input int k, input int pulse_at);
      int cyc;
      @(negedge clk);
      if (k == 0) start_m = 1'b0; else start_s = 1'b0;
      @(negedge clk);
      if (k == 0) start_m = 1'b1; else start_s = 1'b1;
      wait_done(k, pulse_at, cyc);
      check("latency", k, 32'(cyc - 1), 32'(n_of(k)));
   endtask

   task automatic fill_main_random();
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 24; c++)
            fm[r][c] = 8'($urandom_range(0, 255));
   endtask

   task automatic fill_small_random();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            fo[r][c] = 8'($urandom_range(0, 254));
      for (int x = 0; x < 5; x++) begin
         fo[4][x] = 8'hFF;
         fo[x][4] = 8'hFF;
      end
   endtask

   // ---------------- main sequence ----------------
   int nz;
   initial begin
      rst = 1'b0;
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 24; c++) fm[r][c] = 8'h00;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) fo[r][c] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_busy", 0, 32'(m_if.busy), 32'h0);
      check("reset_done", 0, 32'(m_if.layer_done_out), 32'h0);
      check("reset_pool", 0, 32'(m_if.pool_out[11][11]), 32'h0);
      rst = 1'b1;

      // ramp map, including windows that wrap past 255
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 24; c++) fm[r][c] = 8'((r * 24 + c) % 256);
      run(0, 0);
      @(negedge clk);
      check("model_ramp_00", 0, 32'(exp_pool[0][0][0]), 32'd25);
      check("ramp_00", 0, 32'(m_if.pool_out[0][0]), 32'd25);
      check("ramp_50_wrap", 0, 32'(m_if.pool_out[5][0]), 32'd241);
      check("ramp_1111", 0, 32'(m_if.pool_out[11][11]), 32'd63);

      // start held high after done: no re-run
      repeat (20) @(negedge clk);
      check("hold_done", 0, 32'(m_if.layer_done_out), 32'h1);
      check("hold_busy", 0, 32'(m_if.busy), 32'h0);

      // drop then raise: recompute on new data
      fill_main_random();
      run(0, 0);

      // start pulse inside RUN is ignored
      fill_main_random();
      run(0, 100);

      // signed vs unsigned window, odd dimensions with 8'hFF on ignored row/col
      fill_small_random();
      fo[0][0] = 8'hFE; fo[0][1] = 8'h04; fo[1][0] = 8'hFF; fo[1][1] = 8'h80;
      run(1, 0);
      @(negedge clk);
      check("unsigned_window", 1, 32'(o_if.pool_out[0][0]), 32'hFF);
      check("signed_window", 2, 32'(s_if.pool_out[0][0]), 32'h04);
      check("model_signed", 2, 32'(exp_pool[2][0][0]), 32'h04);
      for (int t = 0; t < 4; t++) begin
         fill_small_random();
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) fo[r][c] = 8'($urandom_range(0, 255));
         run(1, 0);
      end

      // async reset in the middle of a run
      fill_main_random();
      @(negedge clk); start_m = 1'b0;
      @(negedge clk); start_m = 1'b1;
      repeat (200) @(posedge clk);
      #2;
      rst = 1'b0;
      start_m = 1'b0;
      start_s = 1'b0;
      #1;
      check("async_busy", 0, 32'(m_if.busy), 32'h0);
      check("async_done", 0, 32'(m_if.layer_done_out), 32'h0);
      check("async_done_small", 1, 32'(o_if.layer_done_out), 32'h0);
      nz = 0;
      for (int i = 0; i < 12; i++)
         for (int j = 0; j < 12; j++)
            if (m_if.pool_out[i][j] != 8'h00) nz++;
      check("async_pool_nonzero", 0, 32'(nz), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      fill_main_random();
      run(0, 0);
      fill_small_random();
      run(1, 0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
